// File: rtl/demux_8bit_deserializer.sv
// 1-to-8 demultiplexing deserializer: a 3-bit select counter steers serial bits
// into a shadow word, which is handed off on a registered valid/ready output slot.
module demux_8bit_deserializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  input  logic       in_valid,
  input  logic       start,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] sel_cnt,
  output logic       busy,
  output logic       overrun
);

  logic [2:0] sel_q, sel_d;
  logic [7:0] shadow_q, shadow_d;
  logic       busy_q, busy_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;
  logic       overrun_q, overrun_d;

  logic [2:0] base_sel;
  logic [7:0] base_shadow;
  logic       base_busy;
  logic [2:0] idx;
  logic [7:0] word;
  logic       complete;
  logic       slot_free;

  always_comb begin
    // A start realigns first, so a same-cycle bit lands at index 0 of the new word.
    base_sel    = start ? 3'd0 : sel_q;
    base_shadow = start ? 8'h00 : shadow_q;
    base_busy   = start ? 1'b0 : busy_q;
    idx         = LSB_FIRST ? base_sel : (3'd7 - base_sel);
    word        = base_shadow;
    word[idx]   = in;
    complete    = in_valid && (base_sel == 3'd7);
    // Accept-and-refill in the same cycle counts as a free slot.
    slot_free   = !out_valid_q || out_ready;

    sel_d       = base_sel;
    shadow_d    = base_shadow;
    busy_d      = base_busy;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
    overrun_d   = start ? 1'b0 : overrun_q;

    if (in_valid) begin
      if (complete) begin
        sel_d    = 3'd0;
        shadow_d = 8'h00;
        busy_d   = 1'b0;
        if (slot_free) begin
          out_d       = word;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        sel_d    = base_sel + 3'd1;
        shadow_d = word;
        busy_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q       <= 3'd0;
      shadow_q    <= 8'h00;
      busy_q      <= 1'b0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      shadow_q    <= shadow_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel_cnt   = sel_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_demux_8bit_deserializer.sv
// Bench for demux_8bit_deserializer: LSB-first and MSB-first instances share one
// stimulus stream and are compared against a word-level reference model.
module tb_demux_8bit_deserializer;

  logic clk = 1'b0;
  logic rst_n, in_b, in_valid, start, out_ready;
  logic [7:0] out_l, out_m;
  logic       vld_l, vld_m, busy_l, busy_m, ovr_l, ovr_m;
  logic [2:0] sel_l, sel_m;

  int checks = 0;
  int failures = 0;

  // Reference model state; index 0 = LSB-first, 1 = MSB-first.
  logic [7:0] m_out[2];
  logic [7:0] m_sh[2];
  int         m_cnt[2];
  bit         m_ov[2];
  bit         m_ovr[2];

  always #5 clk = ~clk;

  demux_8bit_deserializer #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in(in_b), .in_valid(in_valid), .start(start),
    .out(out_l), .out_valid(vld_l), .out_ready(out_ready), .sel_cnt(sel_l),
    .busy(busy_l), .overrun(ovr_l));

  demux_8bit_deserializer #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in(in_b), .in_valid(in_valid), .start(start),
    .out(out_m), .out_valid(vld_m), .out_ready(out_ready), .sel_cnt(sel_m),
    .busy(busy_m), .overrun(ovr_m));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic iv, input logic b,
                              input logic st, input logic rdy);
    for (int p = 0; p < 2; p++) begin
      bit free;
      int pos;
      if (!r) begin
        m_out[p] = 8'h00; m_sh[p] = 8'h00; m_cnt[p] = 0; m_ov[p] = 0; m_ovr[p] = 0;
      end else begin
        free = !m_ov[p] || rdy;
        if (st) begin
          m_cnt[p] = 0; m_sh[p] = 8'h00; m_ovr[p] = 0;
        end
        if (m_ov[p] && rdy) m_ov[p] = 0;
        if (iv) begin
          pos = (p == 0) ? m_cnt[p] : 7 - m_cnt[p];
          m_sh[p][pos] = b;
          m_cnt[p]++;
          if (m_cnt[p] == 8) begin
            if (free) begin
              m_out[p] = m_sh[p];
              m_ov[p]  = 1;
            end else begin
              m_ovr[p] = 1;
            end
            m_cnt[p] = 0;
            m_sh[p]  = 8'h00;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("model_out_l",  out_l,  m_out[0]);
    chk("model_vld_l",  vld_l,  m_ov[0]);
    chk("model_sel_l",  sel_l,  m_cnt[0]);
    chk("model_busy_l", busy_l, m_cnt[0] != 0);
    chk("model_ovr_l",  ovr_l,  m_ovr[0]);
    chk("model_out_m",  out_m,  m_out[1]);
    chk("model_vld_m",  vld_m,  m_ov[1]);
    chk("model_sel_m",  sel_m,  m_cnt[1]);
    chk("model_busy_m", busy_m, m_cnt[1] != 0);
    chk("model_ovr_m",  ovr_m,  m_ovr[1]);
  endtask

  task automatic step(input logic r, input logic iv, input logic b,
                      input logic st, input logic rdy);
    rst_n = r; in_valid = iv; in_b = b; start = st; out_ready = rdy;
    @(posedge clk);
    model_update(r, iv, b, st, rdy);
    #1;
    compare_model();
  endtask

  task automatic send_byte(input logic [7:0] w, input logic rdy);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, w[i], 1'b0, rdy);
  endtask

  typedef struct {
    logic       r, iv, b, st, rdy;
    logic [2:0] e_sel;
    logic       e_busy, e_vld;
    logic [7:0] e_out_l, e_out_m;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_b = 1'b0; start = 1'b0; out_ready = 1'b0;

    // Reset, then stream 1,0,1,1,0,0,1,0 with out_ready high.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 8'h4D, 8'hB2};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h4D, 8'hB2};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, vecs[i].iv, vecs[i].b, vecs[i].st, vecs[i].rdy);
      chk($sformatf("vec%0d_sel", i),   sel_l,  vecs[i].e_sel);
      chk($sformatf("vec%0d_busy", i),  busy_l, vecs[i].e_busy);
      chk($sformatf("vec%0d_vld", i),   vld_l,  vecs[i].e_vld);
      chk($sformatf("vec%0d_out_l", i), out_l,  vecs[i].e_out_l);
      chk($sformatf("vec%0d_out_m", i), out_m,  vecs[i].e_out_m);
    end

    // Overrun with consumer stalled.
    send_byte(8'hA5, 1'b0);
    chk("ovr_first_vld", vld_l, 1'b1);
    chk("ovr_first_out", out_l, 8'hA5);
    send_byte(8'h3C, 1'b0);
    chk("ovr_keep_out", out_l, 8'hA5);
    chk("ovr_keep_vld", vld_l, 1'b1);
    chk("ovr_flag", ovr_l, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drain_vld", vld_l, 1'b0);
    chk("ovr_sticky", ovr_l, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_start_clear", ovr_l, 1'b0);
    chk("ovr_start_out", out_l, 8'hA5);

    // Back-to-back words, in_valid toggling, ready only on the second completion.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, i < 4, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("b2b_first_out", out_l, 8'h0F);
    chk("b2b_first_vld", vld_l, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, i >= 4, 1'b0, i == 7);
      if (i < 7) chk("b2b_hold_out", out_l, 8'h0F);
      chk("b2b_hold_vld", vld_l, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("b2b_second_out", out_l, 8'hF0);
    chk("b2b_second_out_m", out_m, 8'h0F);
    chk("b2b_no_ovr", ovr_l, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_drained", vld_l, 1'b0);

    // Partial-word abort with a same-cycle captured bit.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("abort_sel5", sel_l, 3'd5);
    chk("abort_busy5", busy_l, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_sel1", sel_l, 3'd1);
    chk("abort_busy1", busy_l, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_out_l", out_l, 8'h01);
    chk("abort_out_m", out_m, 8'h80);
    chk("abort_vld", vld_l, 1'b1);

    // Reset in the middle of a word.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_out", out_l, 8'h00);
    chk("rst_vld", vld_l, 1'b0);
    chk("rst_sel", sel_l, 3'd0);
    chk("rst_busy", busy_l, 1'b0);
    chk("rst_ovr", ovr_l, 1'b0);
    send_byte(8'h96, 1'b1);
    chk("post_rst_out_l", out_l, 8'h96);
    chk("post_rst_out_m", out_m, 8'h69);
    chk("post_rst_vld", vld_l, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 200) != 0, ($urandom % 4) != 0, $urandom % 2,
           ($urandom % 64) == 0, ($urandom % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
